// File: rtl/vga_rom_pkg.sv
// Shared constants and types for the image ROM read-port arbiter.
// The 1-bit port id is carried through the tag pipeline alongside a valid bit.
package vga_rom_pkg;

    localparam int ROM_ADDR_W = 19;
    localparam int ROM_DATA_W = 12;

    localparam logic PORT_BG  = 1'b0;
    localparam logic PORT_OVL = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } rom_tag_t;

endpackage

// File: rtl/rom_tag_pipe.sv
// Fixed-depth shift register of {valid, id} tags with synchronous clear.
// Clearing drops every in-flight tag and also discards the tag presented this cycle.
module rom_tag_pipe
    import vga_rom_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk_i,
    input  logic     clr_i,
    input  rom_tag_t tag_i,
    output rom_tag_t tag_o
);

    rom_tag_t stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/image_rom_arbiter.sv
// Shares one registered-output image ROM read port between the VGA background
// fetch (port 0, priority) and overlay logic (port 1, with a starvation guard).
module image_rom_arbiter
    import vga_rom_pkg::*;
#(
    parameter int ADDR_WIDTH   = ROM_ADDR_W,
    parameter int DATA_WIDTH   = ROM_DATA_W,
    parameter int ROM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_dout
);

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
    localparam int         TAG_DEPTH  = ROM_LATENCY + 1;

    logic [7:0]            starve_q;
    logic [7:0]            starve_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q;
    logic [ADDR_WIDTH-1:0] rom_addr_d;
    logic                  force_ovl;
    logic                  grant0;
    logic                  grant1;
    rom_tag_t              tag_in;
    rom_tag_t              tag_out;

    // Port 1 wins only when forced or when port 0 is idle.
    always_comb begin
        force_ovl = (starve_q == STARVE_MAX) && req1_valid;
        grant1    = force_ovl || (!req0_valid && req1_valid);
        grant0    = req0_valid && !force_ovl;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        starve_d = starve_q;
        if (!req1_valid || grant1) begin
            starve_d = 8'd0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_comb begin
        rom_addr_d = rom_addr_q;
        if (grant0) begin
            rom_addr_d = req0_addr;
        end else if (grant1) begin
            rom_addr_d = req1_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q   <= 8'd0;
            rom_addr_q <= '0;
        end else begin
            starve_q   <= starve_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    assign rom_addr = rom_addr_q;

    always_comb begin
        tag_in       = '0;
        tag_in.valid = grant0 || grant1;
        tag_in.id    = grant1 ? PORT_OVL : PORT_BG;
    end

    // One stage for the address register plus ROM_LATENCY for the BRAM itself.
    rom_tag_pipe #(
        .DEPTH(TAG_DEPTH)
    ) u_tag_pipe (
        .clk_i (clk),
        .clr_i (rst),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    assign rsp0_valid = tag_out.valid && (tag_out.id == PORT_BG);
    assign rsp1_valid = tag_out.valid && (tag_out.id == PORT_OVL);
    assign rsp0_data  = rom_dout;
    assign rsp1_data  = rom_dout;

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Bench for image_rom_arbiter: two builds (latency 1 / limit 8 and latency 3 /
// limit 1) driven with the same stimulus, each checked against a queue model.
module tb_image_rom_arbiter;

    localparam int LAT_A = 1;
    localparam int LIM_A = 8;
    localparam int LAT_B = 3;
    localparam int LIM_B = 1;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [18:0] req0_addr;
    logic        req1_valid;
    logic [18:0] req1_addr;

    logic [1:0]        rdy0;
    logic [1:0]        rdy1;
    logic [1:0]        rv0;
    logic [1:0]        rv1;
    logic [1:0][11:0]  rd0;
    logic [1:0][11:0]  rd1;
    logic [1:0][18:0]  rom_addr;
    logic [1:0][11:0]  rom_dout;

    typedef struct packed {
        logic [31:0] due;
        logic        port;
        logic [11:0] data;
    } exp_t;

    exp_t        exp_q_a[$];
    exp_t        exp_q_b[$];
    int          m_starve [2];
    logic [18:0] m_rom_addr [2];
    int          cyc;
    int          n_checks;
    int          n_pass;

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUTs ----------------
    image_rom_arbiter #(.ROM_LATENCY(LAT_A), .STARVE_LIMIT(LIM_A)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_ready (rdy0[0]),
        .rsp0_valid (rv0[0]),
        .rsp0_data  (rd0[0]),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_ready (rdy1[0]),
        .rsp1_valid (rv1[0]),
        .rsp1_data  (rd1[0]),
        .rom_addr   (rom_addr[0]),
        .rom_dout   (rom_dout[0])
    );

    image_rom_arbiter #(.ROM_LATENCY(LAT_B), .STARVE_LIMIT(LIM_B)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_ready (rdy0[1]),
        .rsp0_valid (rv0[1]),
        .rsp0_data  (rd0[1]),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_ready (rdy1[1]),
        .rsp1_valid (rv1[1]),
        .rsp1_data  (rd1[1]),
        .rom_addr   (rom_addr[1]),
        .rom_dout   (rom_dout[1])
    );

    // ---------------- ROM models: mem[a] = a[11:0] ----------------
    logic [11:0] rom_a_q;
    logic [11:0] rom_b1_q;
    logic [11:0] rom_b2_q;
    logic [11:0] rom_b3_q;

    always @(posedge clk) begin
        rom_a_q  <= rom_addr[0][11:0];
        rom_b1_q <= rom_addr[1][11:0];
        rom_b2_q <= rom_b1_q;
        rom_b3_q <= rom_b2_q;
    end

    assign rom_dout[0] = rom_a_q;
    assign rom_dout[1] = rom_b3_q;

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_step(input int k, input int lat, input int lim);
        bit          f;
        bit          g0;
        bit          g1;
        bit          have;
        exp_t        e;
        logic [18:0] ga;
        f  = (m_starve[k] == lim) && req1_valid;
        g1 = f || (!req0_valid && req1_valid);
        g0 = req0_valid && !f;
        chk($sformatf("ready0[%0d]", k), 32'(rdy0[k]), 32'(g0));
        chk($sformatf("ready1[%0d]", k), 32'(rdy1[k]), 32'(g1));

        have = 1'b0;
        e    = '0;
        if (k == 0 && exp_q_a.size() > 0 && exp_q_a[0].due == 32'(cyc)) begin
            have = 1'b1;
            e    = exp_q_a.pop_front();
        end
        if (k == 1 && exp_q_b.size() > 0 && exp_q_b[0].due == 32'(cyc)) begin
            have = 1'b1;
            e    = exp_q_b.pop_front();
        end
        chk($sformatf("rsp0_valid[%0d]", k), 32'(rv0[k]), 32'(have && !e.port));
        chk($sformatf("rsp1_valid[%0d]", k), 32'(rv1[k]), 32'(have && e.port));
        if (have) begin
            chk($sformatf("rsp_data[%0d]", k), 32'(e.port ? rd1[k] : rd0[k]), 32'(e.data));
        end
        chk($sformatf("rom_addr[%0d]", k), 32'(rom_addr[k]), 32'(m_rom_addr[k]));

        if (rst) begin
            m_starve[k]   = 0;
            m_rom_addr[k] = '0;
            if (k == 0) exp_q_a.delete();
            else exp_q_b.delete();
        end else begin
            if (g0 || g1) begin
                ga            = g1 ? req1_addr : req0_addr;
                m_rom_addr[k] = ga;
                e.due         = 32'(cyc + lat + 1);
                e.port        = g1;
                e.data        = ga[11:0];
                if (k == 0) exp_q_a.push_back(e);
                else exp_q_b.push_back(e);
            end
            if (g1 || !req1_valid) m_starve[k] = 0;
            else if (m_starve[k] < lim) m_starve[k] = m_starve[k] + 1;
        end
    endtask

    initial begin
        cyc           = 0;
        m_starve[0]   = 0;
        m_starve[1]   = 0;
        m_rom_addr[0] = '0;
        m_rom_addr[1] = '0;
    end

    always @(negedge clk) begin
        model_step(0, LAT_A, LIM_A);
        model_step(1, LAT_B, LIM_B);
        cyc++;
    end

    // ---------------- driver ----------------
    task automatic drive(input logic v0, input logic [18:0] a0,
                         input logic v1, input logic [18:0] a1, input logic r);
        @(posedge clk);
        #1;
        rst        = r;
        req0_valid = v0;
        req0_addr  = a0;
        req1_valid = v1;
        req1_addr  = a1;
    endtask

    function automatic logic [18:0] rand_addr();
        return 19'($urandom_range(0, 19'h7FFFF));
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst        = 1'b1;
        req0_valid = 1'b0;
        req0_addr  = '0;
        req1_valid = 1'b0;
        req1_addr  = '0;
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, '0, 1'b1);

        // quiet after reset
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, '0, 1'b0, '0, 1'b0);
            @(negedge clk);
            chk("idle_rsp0", 32'(rv0[0]), 32'd0);
            chk("idle_rsp1", 32'(rv1[0]), 32'd0);
            chk("idle_rom_addr", 32'(rom_addr[0]), 32'd0);
        end

        // single port 0 read, response two cycles later
        drive(1'b1, 19'h00010, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("single_ready0", 32'(rdy0[0]), 32'd1);
        idle(1);
        idle(1);
        @(negedge clk);
        chk("single_rsp0_valid", 32'(rv0[0]), 32'd1);
        chk("single_rsp0_data", 32'(rd0[0]), 32'h010);
        idle(4);

        // alternating ports, responses back to back
        drive(1'b1, 19'h00100, 1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1, 19'h00200, 1'b0);
        idle(1);
        @(negedge clk);
        chk("alt_rsp0_valid", 32'(rv0[0]), 32'd1);
        chk("alt_rsp0_data", 32'(rd0[0]), 32'h100);
        chk("alt_rsp1_early", 32'(rv1[0]), 32'd0);
        idle(1);
        @(negedge clk);
        chk("alt_rsp1_valid", 32'(rv1[0]), 32'd1);
        chk("alt_rsp1_data", 32'(rd1[0]), 32'h200);
        chk("alt_rsp0_after", 32'(rv0[0]), 32'd0);
        idle(4);

        // latency-3 build, port 1 alone at the top address
        drive(1'b0, '0, 1'b1, 19'h7FFFF, 1'b0);
        @(negedge clk);
        chk("lat3_ready1", 32'(rdy1[1]), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            idle(1);
            @(negedge clk);
            if (i < 4) begin
                chk("lat3_rsp1_early", 32'(rv1[1]), 32'd0);
            end else begin
                chk("lat3_rsp1_valid", 32'(rv1[1]), 32'd1);
                chk("lat3_rsp1_data", 32'(rd1[1]), 32'hFFF);
            end
        end
        idle(3);

        // both ports requesting continuously
        for (int i = 0; i < 27; i++) begin
            drive(1'b1, rand_addr(), 1'b1, rand_addr(), 1'b0);
            @(negedge clk);
            chk("starve_pattern_a", 32'(rdy1[0]), 32'((i % 9) == 8));
            chk("starve_pattern_b", 32'(rdy1[1]), 32'((i % 2) == 1));
            chk("one_grant_a", 32'(rdy0[0] & rdy1[0]), 32'd0);
        end
        idle(6);

        // reset one cycle after a port 1 grant drops its response
        drive(1'b0, '0, 1'b1, 19'h00345, 1'b0);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            idle(1);
            @(negedge clk);
            chk("rst_drop_a", 32'(rv1[0]), 32'd0);
            chk("rst_drop_b", 32'(rv1[1]), 32'd0);
        end

        // reset clears a partially counted starvation run
        for (int i = 0; i < 4; i++) drive(1'b1, rand_addr(), 1'b1, rand_addr(), 1'b0);
        drive(1'b1, rand_addr(), 1'b1, rand_addr(), 1'b1);
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, rand_addr(), 1'b1, rand_addr(), 1'b0);
            @(negedge clk);
            chk("starve_clear_a", 32'(rdy1[0]), 32'(i == 8));
        end
        idle(6);

        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 9) < 6), rand_addr(),
                  1'($urandom_range(0, 9) < 6), rand_addr(),
                  1'($urandom_range(0, 63) == 0));
        end
        idle(8);
        @(negedge clk);
        chk("drain_a", 32'(exp_q_a.size()), 32'd0);
        chk("drain_b", 32'(exp_q_b.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
